// File: rtl/ptw_pkg.sv
// Shared types and constants for the page-table walker.
// Holds the walker state enum, PTE bit positions, the packed PTE layout
// and the VPN/PPN widths used by the walker, its interface and pte_check.
package ptw_pkg;

    localparam int VPN_W         = 20;
    localparam int PPN_W         = 22;
    localparam int VPN_PART_W    = 10;
    localparam int PAGE_OFFSET_W = 12;

    localparam int PTE_V_BIT   = 0;
    localparam int PTE_R_BIT   = 1;
    localparam int PTE_W_BIT   = 2;
    localparam int PTE_X_BIT   = 3;
    localparam int PTE_PPN_LSB = 10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_L1_REQ  = 3'd1,
        S_L1_WAIT = 3'd2,
        S_L0_REQ  = 3'd3,
        S_L0_WAIT = 3'd4,
        S_DONE    = 3'd5,
        S_FAULT   = 3'd6
    } ptw_state_e;

    typedef struct packed {
        logic [PPN_W-1:0] ppn;   // bits 31:10
        logic [1:0]       rsw;   // bits 9:8
        logic             d;     // bit 7
        logic             a;     // bit 6
        logic             g;     // bit 5
        logic             u;     // bit 4
        logic             x;     // bit 3
        logic             w;     // bit 2
        logic             r;     // bit 1
        logic             v;     // bit 0
    } pte_t;

endpackage

// File: rtl/page_table_walker_if.sv
// Bus bundle for the page-table walker.
// Miss request (i_miss_*, o_miss_ready, i_ptbr), PTE memory read
// request/response (o_mem_req_*, i_mem_req_ready, i_mem_resp_*),
// TLB fill (o_tlb_write_*), fault strobe and busy flag.
// slave  : the walker side.
// master : the environment side (TLB miss source + memory).
interface page_table_walker_if
    import ptw_pkg::*;
#(
    parameter int VA_WIDTH  = 32,
    parameter int PA_WIDTH  = 34,
    parameter int PTE_WIDTH = 32
) ();

    logic                 i_miss_valid;
    logic [VA_WIDTH-1:0]  i_miss_vaddr;
    logic                 o_miss_ready;
    logic [PPN_W-1:0]     i_ptbr;

    logic                 o_mem_req_valid;
    logic                 i_mem_req_ready;
    logic [PA_WIDTH-1:0]  o_mem_req_addr;
    logic                 i_mem_resp_valid;
    logic [PTE_WIDTH-1:0] i_mem_resp_data;

    logic                 o_tlb_write_enable;
    logic [VPN_W-1:0]     o_tlb_write_vpn;
    logic [PPN_W-1:0]     o_tlb_write_ppn;
    logic                 o_fault;
    logic                 o_busy;

    modport slave (
        input  i_miss_valid, i_miss_vaddr, i_ptbr,
        input  i_mem_req_ready, i_mem_resp_valid, i_mem_resp_data,
        output o_miss_ready, o_mem_req_valid, o_mem_req_addr,
        output o_tlb_write_enable, o_tlb_write_vpn, o_tlb_write_ppn,
        output o_fault, o_busy
    );

    modport master (
        output i_miss_valid, i_miss_vaddr, i_ptbr,
        output i_mem_req_ready, i_mem_resp_valid, i_mem_resp_data,
        input  o_miss_ready, o_mem_req_valid, o_mem_req_addr,
        input  o_tlb_write_enable, o_tlb_write_vpn, o_tlb_write_ppn,
        input  o_fault, o_busy
    );

endinterface

// File: rtl/pte_check.sv
// Combinational PTE decode.
// pte        : PTE as returned by memory
// valid      : V set and not the reserved R=0/W=1 encoding
// leaf       : R or X set (translation ends here)
// misaligned : low 10 PPN bits non-zero (illegal for a level-1 superpage)
module pte_check
    import ptw_pkg::*;
(
    input  pte_t pte,
    output logic valid,
    output logic leaf,
    output logic misaligned
);

    assign valid      = pte.v & ~(~pte.r & pte.w);
    assign leaf       = pte.r | pte.x;
    assign misaligned = |pte.ppn[VPN_PART_W-1:0];

    logic unused_pte_bits;
    assign unused_pte_bits = ^{pte.ppn[PPN_W-1:VPN_PART_W], pte.rsw,
                               pte.d, pte.a, pte.g, pte.u};

endmodule

// File: rtl/page_table_walker.sv
// Two-level page-table walker.
// clk : single clock, rising edge
// rst : synchronous active-low reset
// bus : slave side of page_table_walker_if (miss in, PTE reads out,
//       TLB fill / fault strobes, busy)
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | ready for a miss
// S_L1_REQ  | level-1 PTE read request held until accepted
// S_L1_WAIT | waiting for the level-1 PTE
// S_L0_REQ  | level-0 PTE read request held until accepted
// S_L0_WAIT | waiting for the level-0 PTE
// S_DONE    | one-cycle TLB fill strobe
// S_FAULT   | one-cycle page-fault strobe
module page_table_walker
    import ptw_pkg::*;
#(
    parameter int VA_WIDTH  = 32,
    parameter int PA_WIDTH  = 34,
    parameter int PTE_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    page_table_walker_if.slave  bus
);

    ptw_state_e        state_q, state_d;
    logic [VPN_W-1:0]  vpn_q;
    logic [PPN_W-1:0]  ptbr_q;
    logic [PPN_W-1:0]  pte_ppn_q;
    logic [PPN_W-1:0]  fill_ppn_q;

    pte_t              resp_pte;
    logic              pte_valid, pte_leaf, pte_misaligned;
    logic [PA_WIDTH-1:0] l1_addr, l0_addr;

    assign resp_pte = pte_t'(bus.i_mem_resp_data[31:0]);

    pte_check u_pte_check (
        .pte        (resp_pte),
        .valid      (pte_valid),
        .leaf       (pte_leaf),
        .misaligned (pte_misaligned)
    );

    // Index * 4 is done as a 2-bit shift; both terms are zero-extended.
    assign l1_addr = PA_WIDTH'({ptbr_q, {PAGE_OFFSET_W{1'b0}}})
                   + PA_WIDTH'({vpn_q[VPN_W-1:VPN_PART_W], 2'b00});
    assign l0_addr = PA_WIDTH'({pte_ppn_q, {PAGE_OFFSET_W{1'b0}}})
                   + PA_WIDTH'({vpn_q[VPN_PART_W-1:0], 2'b00});

    always_comb begin
        state_d                = state_q;
        bus.o_miss_ready       = 1'b0;
        bus.o_mem_req_valid    = 1'b0;
        bus.o_mem_req_addr     = '0;
        bus.o_tlb_write_enable = 1'b0;
        bus.o_fault            = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.o_miss_ready = 1'b1;
                if (bus.i_miss_valid) state_d = S_L1_REQ;
            end
            S_L1_REQ: begin
                bus.o_mem_req_valid = 1'b1;
                bus.o_mem_req_addr  = l1_addr;
                if (bus.i_mem_req_ready) state_d = S_L1_WAIT;
            end
            S_L1_WAIT: begin
                if (bus.i_mem_resp_valid) begin
                    if (!pte_valid)          state_d = S_FAULT;
                    else if (!pte_leaf)      state_d = S_L0_REQ;
                    else if (pte_misaligned) state_d = S_FAULT;
                    else                     state_d = S_DONE;
                end
            end
            S_L0_REQ: begin
                bus.o_mem_req_valid = 1'b1;
                bus.o_mem_req_addr  = l0_addr;
                if (bus.i_mem_req_ready) state_d = S_L0_WAIT;
            end
            S_L0_WAIT: begin
                if (bus.i_mem_resp_valid) begin
                    // A pointer at the last level has nowhere left to go.
                    if (pte_valid && pte_leaf) state_d = S_DONE;
                    else                       state_d = S_FAULT;
                end
            end
            S_DONE: begin
                bus.o_tlb_write_enable = 1'b1;
                state_d = S_IDLE;
            end
            S_FAULT: begin
                bus.o_fault = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            vpn_q      <= '0;
            ptbr_q     <= '0;
            pte_ppn_q  <= '0;
            fill_ppn_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && bus.i_miss_valid) begin
                vpn_q  <= bus.i_miss_vaddr[31:12];
                ptbr_q <= bus.i_ptbr;
            end
            if (state_q == S_L1_WAIT && bus.i_mem_resp_valid) begin
                pte_ppn_q  <= resp_pte.ppn;
                // Superpage: upper PPN from the PTE, lower part from the VA.
                fill_ppn_q <= {resp_pte.ppn[PPN_W-1:VPN_PART_W], vpn_q[VPN_PART_W-1:0]};
            end
            if (state_q == S_L0_WAIT && bus.i_mem_resp_valid) begin
                fill_ppn_q <= resp_pte.ppn;
            end
        end
    end

    assign bus.o_busy          = (state_q != S_IDLE);
    assign bus.o_tlb_write_vpn = vpn_q;
    assign bus.o_tlb_write_ppn = fill_ppn_q;

    logic unused_vaddr_bits;
    assign unused_vaddr_bits = ^bus.i_miss_vaddr[11:0];

endmodule

// File: doc/page_table_walker.md
PAGE_TABLE_WALKER -- requirements
Module: page_table_walker

Interface
REQ-001 Parameters SHALL be: VA_WIDTH, default 32, virtual address width; PA_WIDTH, default 34, physical address width; PTE_WIDTH, default 32, page-table entry width.
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 Port rst SHALL be: input, 1 bit, synchronous active-low reset.
REQ-004 Port i_miss_valid SHALL be: input, 1 bit, translation miss request.
REQ-005 Port i_miss_vaddr SHALL be: input, VA_WIDTH bits, missing virtual address.
REQ-006 Port o_miss_ready SHALL be: output, 1 bit, walker can accept a miss.
REQ-007 Port i_ptbr SHALL be: input, 22 bits, root page-table physical page number.
REQ-008 Port o_mem_req_valid SHALL be: output, 1 bit, PTE read request.
REQ-009 Port i_mem_req_ready SHALL be: input, 1 bit, memory accepts the request.
REQ-010 Port o_mem_req_addr SHALL be: output, PA_WIDTH bits, PTE physical address.
REQ-011 Port i_mem_resp_valid SHALL be: input, 1 bit, PTE data valid.
REQ-012 Port i_mem_resp_data SHALL be: input, PTE_WIDTH bits, PTE data.
REQ-013 Port o_tlb_write_enable SHALL be: output, 1 bit, one-cycle TLB fill strobe.
REQ-014 Port o_tlb_write_vpn SHALL be: output, 20 bits, virtual page number (vaddr[31:12]).
REQ-015 Port o_tlb_write_ppn SHALL be: output, 22 bits, physical page number.
REQ-016 Port o_fault SHALL be: output, 1 bit, one-cycle page-fault strobe.
REQ-017 Port o_busy SHALL be: output, 1 bit, asserted whenever state is not IDLE.

Function
REQ-018 FSM states SHALL be: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE, FAULT.
REQ-019 o_miss_ready SHALL be 1 only in IDLE; a miss is accepted on i_miss_valid && o_miss_ready, which latches vaddr and ptbr and moves to L1_REQ.
REQ-020 In L1_REQ the walker SHALL drive o_mem_req_valid=1 and o_mem_req_addr={ptbr,12'b0}+vaddr[31:22]*4.
REQ-021 In L0_REQ the walker SHALL drive o_mem_req_valid=1 and o_mem_req_addr={pte.ppn,12'b0}+vaddr[21:12]*4.
REQ-022 o_mem_req_valid and o_mem_req_addr SHALL hold stable until i_mem_req_ready; the request completes on that edge, advancing REQ to WAIT.
REQ-023 i_mem_resp_valid SHALL be sampled only in WAIT states; responses in any other state are ignored.
REQ-024 PTE bit fields SHALL be: V=bit0, R=bit1, W=bit2, X=bit3, ppn=bits[31:10].
REQ-025 A PTE with V=0, or with R=0 and W=1, SHALL cause transition to FAULT.
REQ-026 A PTE with R|X=1 SHALL be a leaf; any other valid PTE is a pointer.
REQ-027 From L1_WAIT, a pointer PTE SHALL go to L0_REQ.
REQ-028 From L1_WAIT, a leaf PTE with ppn[9:0]!=0 SHALL go to FAULT (misaligned superpage).
REQ-029 From L1_WAIT, any other leaf PTE SHALL go to DONE with ppn={pte.ppn[21:10], vaddr[21:12]}.
REQ-030 From L0_WAIT, a leaf PTE SHALL go to DONE with ppn=pte.ppn; a pointer PTE SHALL go to FAULT.
REQ-031 DONE SHALL assert o_tlb_write_enable for exactly one cycle with registered vpn and ppn, then return to IDLE.
REQ-032 FAULT SHALL assert o_fault for exactly one cycle, with no TLB write, then return to IDLE.
REQ-033 Latency SHALL be: miss accepted at edge T gives the earliest L1 leaf fill strobe in cycle T+3 (ready=1, response in cycle T+2); each pointer level adds 2 cycles.
REQ-034 A new miss SHALL NOT be accepted in DONE or FAULT; the earliest acceptance is the cycle after return to IDLE.
REQ-035 Address arithmetic SHALL be unsigned and zero-extended to PA_WIDTH, with no wrap checks.

Reset
REQ-036 rst=0 at a clock edge SHALL force IDLE, clear the latched vaddr, ptbr and PTE, and drive o_mem_req_valid, o_tlb_write_enable, o_fault and o_busy to 0 (o_miss_ready=1 after release).
REQ-037 Reset mid-walk SHALL abandon the walk silently; late memory responses arriving afterwards are ignored.

Structure
REQ-038 Package ptw_pkg SHALL hold the state enum, the PTE bit-position constants, the pte_t packed struct, and the VPN/PPN widths.
REQ-039 One combinational sub-module, pte_check, SHALL decode a PTE into valid/leaf/misaligned flags.

Verification
REQ-040 Two-level walk: ptbr=0x100, vaddr=0x00401ABC; L1 addr 0x00100004 returns 0x00080001; L0 addr 0x00200004 returns 0x048D140F -> one fill strobe, vpn=0x00401, ppn=0x12345.
REQ-041 Superpage: same vaddr, L1 returns 0x0010000B -> fill with ppn=0x00401, no L0 request.
REQ-042 Misaligned superpage: L1 returns 0x0010040B -> o_fault pulse, no fill.
REQ-043 Invalid PTE: L1 returns 0x00000000 -> o_fault pulse; o_miss_ready=1 two cycles later.
REQ-044 Backpressure: i_mem_req_ready=0 for 3 cycles -> valid and addr held unchanged, walk completes normally.
REQ-045 Reset during L0_WAIT, then response delivered -> stays IDLE, no fill, no fault.
